// File: rtl/vuart_reg_arbiter.sv
// vuart_reg_arbiter: shares the single vUART register port between two
// requesters (0 = host CSR decode, 1 = local management agent).
// Round-robin arbitration, one transaction in flight, and an optional
// per-requester lock with an idle timeout that breaks abandoned locks.
//
// Ports:
//   clk_50m, rst_50m      UART-domain clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake (ready is a 1-cycle pulse)
//   req_write/req_lock    per-requester access type and lock request
//   req_addr/req_wdata    packed per-requester address / write data
//   rsp_valid/rsp_rdata   per-requester completion pulse and read data
//   urt_*                 vUART register port (fixed read latency)
//   grant_id              requester owning the current or last transaction
//   lock_active           lock held
//   lock_timeout          1-cycle pulse on forced lock release
module vuart_reg_arbiter #(
    parameter int unsigned ADDR_W       = 9,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned RD_LATENCY   = 1,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic                  clk_50m,
    input  logic                  rst_50m,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_write,
    input  logic [1:0]            req_lock,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [ADDR_W-1:0]     urt_addr,
    output logic                  urt_write,
    output logic [DATA_W-1:0]     urt_writedata,
    output logic                  urt_read,
    input  logic [DATA_W-1:0]     urt_readdata,
    output logic                  grant_id,
    output logic                  lock_active,
    output logic                  lock_timeout
);

    localparam int unsigned RD_CNT_W    = (RD_LATENCY < 2) ? 1 : $clog2(RD_LATENCY);
    localparam int unsigned RD_LAST     = (RD_LATENCY < 1) ? 0 : RD_LATENCY - 1;
    localparam int unsigned TMR_W       = (LOCK_TIMEOUT == 0) ? 1 : $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned TMR_LAST    = (LOCK_TIMEOUT == 0) ? 0 : LOCK_TIMEOUT - 1;
    localparam bit          TIMEOUT_EN  = (LOCK_TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t               state, state_d;
    logic                 last_grant, last_grant_d;
    logic                 grant_id_d;
    logic                 cap_write, cap_write_d;
    logic [ADDR_W-1:0]    urt_addr_d;
    logic [DATA_W-1:0]    urt_writedata_d;
    logic                 urt_write_d, urt_read_d;
    logic [1:0]           rsp_valid_d;
    logic [DATA_W-1:0]    rsp_rdata_d;
    logic [RD_CNT_W-1:0]  rd_cnt, rd_cnt_d;
    logic                 lock_active_d;
    logic                 lock_owner, lock_owner_d;
    logic [TMR_W-1:0]     lock_timer, lock_timer_d;
    logic                 lock_timeout_d;

    logic [1:0]           eligible;
    logic                 winner;
    logic                 accept;
    logic [ADDR_W-1:0]    win_addr;
    logic [DATA_W-1:0]    win_wdata;

    // Arbitration: lock restricts eligibility to the owner, ties go to the
    // requester that did not win last time.
    always_comb begin
        eligible[0] = req_valid[0] && (!lock_active || !lock_owner);
        eligible[1] = req_valid[1] && (!lock_active ||  lock_owner);
        winner      = (eligible == 2'b11) ? ~last_grant : eligible[1];
        accept      = !rst_50m && (state == IDLE) && (eligible != 2'b00);
        win_addr    = winner ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
        win_wdata   = winner ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
        req_ready   = accept ? (2'b01 << winner) : 2'b00;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d         = state;
        last_grant_d    = last_grant;
        grant_id_d      = grant_id;
        cap_write_d     = cap_write;
        urt_addr_d      = urt_addr;
        urt_writedata_d = urt_writedata;
        urt_write_d     = 1'b0;
        urt_read_d      = 1'b0;
        rsp_valid_d     = 2'b00;
        rsp_rdata_d     = '0;
        rd_cnt_d        = rd_cnt;
        lock_active_d   = lock_active;
        lock_owner_d    = lock_owner;
        lock_timer_d    = lock_timer;
        lock_timeout_d  = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    // Strobe registers are loaded here so they appear in ISSUE.
                    state_d         = ISSUE;
                    last_grant_d    = winner;
                    grant_id_d      = winner;
                    cap_write_d     = req_write[winner];
                    urt_addr_d      = win_addr;
                    urt_writedata_d = win_wdata;
                    urt_write_d     = req_write[winner];
                    urt_read_d      = ~req_write[winner];
                    lock_active_d   = req_lock[winner];
                    lock_owner_d    = winner;
                    lock_timer_d    = '0;
                end else if (lock_active && TIMEOUT_EN) begin
                    // Owner is idle here; old lock still governs this cycle.
                    if (lock_timer == TMR_W'(TMR_LAST)) begin
                        lock_active_d  = 1'b0;
                        lock_timeout_d = 1'b1;
                        lock_timer_d   = '0;
                    end else begin
                        lock_timer_d   = lock_timer + 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (cap_write) begin
                    state_d     = RESP;
                    rsp_valid_d = 2'b01 << grant_id;
                end else begin
                    state_d  = WAIT_RD;
                    rd_cnt_d = '0;
                end
            end
            WAIT_RD: begin
                if (rd_cnt == RD_CNT_W'(RD_LAST)) begin
                    state_d     = RESP;
                    rsp_valid_d = 2'b01 << grant_id;
                    rsp_rdata_d = urt_readdata;
                end else begin
                    rd_cnt_d = rd_cnt + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_50m) begin
        if (rst_50m) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            grant_id      <= 1'b0;
            cap_write     <= 1'b0;
            urt_addr      <= '0;
            urt_writedata <= '0;
            urt_write     <= 1'b0;
            urt_read      <= 1'b0;
            rsp_valid     <= 2'b00;
            rsp_rdata     <= '0;
            rd_cnt        <= '0;
            lock_active   <= 1'b0;
            lock_owner    <= 1'b0;
            lock_timer    <= '0;
            lock_timeout  <= 1'b0;
        end else begin
            state         <= state_d;
            last_grant    <= last_grant_d;
            grant_id      <= grant_id_d;
            cap_write     <= cap_write_d;
            urt_addr      <= urt_addr_d;
            urt_writedata <= urt_writedata_d;
            urt_write     <= urt_write_d;
            urt_read      <= urt_read_d;
            rsp_valid     <= rsp_valid_d;
            rsp_rdata     <= rsp_rdata_d;
            rd_cnt        <= rd_cnt_d;
            lock_active   <= lock_active_d;
            lock_owner    <= lock_owner_d;
            lock_timer    <= lock_timer_d;
            lock_timeout  <= lock_timeout_d;
        end
    end

endmodule
